mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit for the core's data port: the initiator of the data-memory interface the RAM model responds to. It accepts one load or store at a time from the execute stage. It drives the RAM's chip-select, word address, write data and byte-write mask, then returns a sign- or zero-extended load result or a store completion. Misaligned and illegal accesses are rejected without touching memory.

## Interface
- `ADDR_WIDTH`, 32, byte-address width (`API_ADDR_WIDTH`)
- `DATA_WIDTH`, 32, data width (`API_DATA_WIDTH`); only 32 supported
- `READ_LATENCY`, 1, cycles from the enable cycle until RAM read data is valid; legal range 1–4
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  LSU can accept; high only in IDLE
- `req_we_i`  in  1  1 = store, 0 = load
- `req_funct3_i`  in  3  RISC-V funct3 (size/sign)
- `req_addr_i`  in  ADDR_WIDTH  byte address
- `req_wdata_i`  in  DATA_WIDTH  store data, right-aligned
- `resp_valid_o`  out  1  one-cycle completion pulse
- `resp_rdata_o`  out  DATA_WIDTH  extended load data; 0 for stores and errors
- `resp_misaligned_o`  out  1  access rejected (misaligned or illegal funct3)
- `mem_en_o`  out  1  RAM chip select
- `mem_address_o`  out  ADDR_WIDTH  full byte address; RAM drops bits [1:0]
- `mem_data_o`  out  DATA_WIDTH  lane-replicated write data
- `mem_wr_mask_o`  out  4  byte-write enables; 0 = read
- `mem_data_i`  in  DATA_WIDTH  RAM read word

## Operation
- Request acceptance: a request is accepted on a rising edge with `req_valid_i & req_ready_o`. Address, funct3, we and wdata are captured into registers; the request inputs are ignored afterwards.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: funct3 000 SB, 001 SH, 010 SW.
- Illegal funct3: any other code (load 011/110/111; store 011 and 1xx).
- Misaligned accesses: halfword with addr[0]=1, or word with addr[1:0]≠0.
- State machine:
  - IDLE: accept a request. Go to RESP if it is misaligned/illegal, otherwise to ISSUE.
  - ISSUE: exactly one cycle with `mem_en_o`=1. Stores go to RESP; loads go to WAIT.
  - WAIT: count READ_LATENCY cycles. Capture `mem_data_i` on the edge ending the last one, then go to RESP.
  - RESP: `resp_valid_o`=1 for one cycle, then go to IDLE.
- Store lane steering, with off = addr[1:0]:
  - SB: mask = 4'b0001 << off, data = {4{wdata[7:0]}}.
  - SH: mask = 4'b0011 << off, data = {2{wdata[15:0]}}.
  - SW: mask = 4'b1111, data = wdata.
- Load in ISSUE: mask = 0.
- Load extraction: byte = word[8·off +: 8]; half = word[16·off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Memory outputs outside ISSUE: `mem_en_o`=0 and `mem_wr_mask_o`=0. `mem_address_o`/`mem_data_o` hold their last value.
- No response backpressure: the consumer must take `resp_valid_o` in its pulse cycle.

## Timing
- Reset: state IDLE, captured request registers cleared, WAIT counter cleared.
- Output values during and after reset:
  - 0: `resp_valid_o`, `resp_rdata_o`, `resp_misaligned_o`, `mem_en_o`, `mem_wr_mask_o`, `mem_address_o`, `mem_data_o`.
  - `req_ready_o` = 0 while reset is asserted, 1 in the first cycle after release.
- Accept edge T0 defines cycle 1 as the cycle after T0.
  - Store: cycle 1 ISSUE (write), cycle 2 `resp_valid_o`.
  - Load: cycle 1 ISSUE, cycles 2..1+READ_LATENCY WAIT, cycle 2+READ_LATENCY `resp_valid_o`. Total is 3 cycles at READ_LATENCY=1.
  - Misaligned/illegal: cycle 1 `resp_valid_o` with `resp_misaligned_o`=1; `mem_en_o` never asserted.
- Back-to-back: the next request can be accepted in the cycle after RESP, so throughput is one store per 3 cycles.
- `resp_rdata_o` and `resp_misaligned_o` are valid only while `resp_valid_o`=1 and are 0 otherwise.
- Reset mid-transaction: the transaction is dropped and no response issues. `mem_en_o` is 0 from the cycle after the reset edge. A write already issued in ISSUE is not undone.
- `req_valid_i` held high during a busy period is not accepted until IDLE. The request is sampled fresh at that point.

## Test plan
- SW addr 0x20, wdata 0xDEADBEEF -> cycle 1: en=1, mask=1111, data=0xDEADBEEF, address=0x20; cycle 2: resp_valid, rdata=0.
- SB addr 0x23, wdata 0x000000A5 -> mask=1000, data=0xA5A5A5A5; a following LW 0x20 returns 0xA5ADBEEF.
- Preload word 0x20=0x80FF7F01, then:
  - LB 0x22 -> 0xFFFFFFFF
  - LBU 0x23 -> 0x00000080
  - LH 0x22 -> 0xFFFF80FF
  - LHU 0x20 -> 0x00007F01
  - each response arrives 3 cycles after accept.
- LH 0x21 and LW 0x22, plus load funct3=011 -> resp_valid with misaligned=1 in cycle 1; mem_en_o stays 0 throughout.
- READ_LATENCY=3 with a delayed-RAM model: LW returns the correct word 5 cycles after accept; req_ready_o is 0 for cycles 1–5.
- Reset asserted in the WAIT cycle of a load -> no resp_valid; all outputs 0; next LW completes normally.

Source files
------------

// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu - load/store unit driving the core's data-memory port.
//
// Takes one load or store at a time from execute. It then issues a single RAM
// access and answers with a one-cycle response. Misaligned accesses and
// unknown funct3 codes are answered at once and never reach memory.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_valid_i/ready_o request handshake (ready only in IDLE)
//   req_we_i            1 = store, 0 = load
//   req_funct3_i        RISC-V funct3 (access size / sign)
//   req_addr_i          byte address
//   req_wdata_i         right-aligned store data
//   resp_valid_o        one-cycle completion pulse
//   resp_rdata_o        extended load data (0 for stores / rejected accesses)
//   resp_misaligned_o   access rejected (misaligned or illegal funct3)
//   mem_en_o            RAM chip select, high only in ISSUE
//   mem_address_o       full byte address (RAM ignores bits [1:0])
//   mem_data_o          lane-replicated store data
//   mem_wr_mask_o       byte-write enables, 0 for reads
//   mem_data_i          RAM read word
// -----------------------------------------------------------------------------
module mem_lsu #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_misaligned_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [3:0]            mem_wr_mask_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Loads only know 000/001/010/100/101; stores only 000/001/010.
    function automatic logic f_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3[2] | (f3[1:0] == 2'b11);
        else
            return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    endfunction

    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_store_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the low lanes lets the byte mask alone select the target bytes.
    function automatic logic [DATA_WIDTH-1:0] f_store_data(input logic [2:0] f3,
                                                           input logic [DATA_WIDTH-1:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_load_extract(input logic [2:0] f3,
                                                             input logic [1:0] off,
                                                             input logic [DATA_WIDTH-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    logic [1:0]            r_state;
    logic                  r_we;
    logic [2:0]            r_f3;
    logic [1:0]            r_off;
    logic                  r_mis;
    logic [3:0]            r_mask;
    logic [2:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_reject;

    assign w_reject = f_illegal(req_we_i, req_funct3_i)
                    | f_misaligned(req_funct3_i, req_addr_i[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_off   <= 2'd0;
            r_mis   <= 1'b0;
            r_mask  <= 4'd0;
            r_cnt   <= 3'd0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_we    <= req_we_i;
                        r_f3    <= req_funct3_i;
                        r_off   <= req_addr_i[1:0];
                        r_mis   <= w_reject;
                        r_rdata <= '0;
                        if (w_reject) begin
                            r_state <= S_RESP;
                        end else begin
                            // Memory-side outputs only change for accesses that reach the RAM.
                            r_addr  <= req_addr_i;
                            r_mask  <= req_we_i ? f_store_mask(req_funct3_i, req_addr_i[1:0]) : 4'd0;
                            if (req_we_i)
                                r_wdata <= f_store_data(req_funct3_i, req_wdata_i);
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= 3'(READ_LATENCY - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Read data is valid in the last WAIT cycle; sample it on the closing edge.
                    if (r_cnt == 3'd0) begin
                        r_rdata <= f_load_extract(r_f3, r_off, mem_data_i);
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o       = (r_state == S_IDLE) & ~reset;
    assign resp_valid_o      = (r_state == S_RESP);
    assign resp_rdata_o      = (r_state == S_RESP) ? r_rdata : '0;
    assign resp_misaligned_o = (r_state == S_RESP) & r_mis;
    assign mem_en_o          = (r_state == S_ISSUE);
    assign mem_wr_mask_o     = (r_state == S_ISSUE) ? r_mask : 4'd0;
    assign mem_address_o     = r_addr;
    assign mem_data_o        = r_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu - bench for mem_lsu. Two instances share a clock and reset:
// u_dut1 (READ_LATENCY=1) and u_dut3 (READ_LATENCY=3). Each one has its own
// byte-maskable RAM model with a matching read delay.
// -----------------------------------------------------------------------------
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        cur;            // 0 selects u_dut1, 1 selects u_dut3
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    always #5 clk = ~clk;

    // instance 1 signals
    logic        rdy1, rv1, mis1, en1;
    logic [31:0] rd1, maddr1, mdata1, mdin1;
    logic [3:0]  mask1;
    // instance 3 signals
    logic        rdy3, rv3, mis3, en3;
    logic [31:0] rd3, maddr3, mdata3, mdin3;
    logic [3:0]  mask3;

    mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid & ~cur), .req_ready_o(rdy1),
        .req_we_i(req_we), .req_funct3_i(req_f3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(rv1), .resp_rdata_o(rd1), .resp_misaligned_o(mis1),
        .mem_en_o(en1), .mem_address_o(maddr1), .mem_data_o(mdata1),
        .mem_wr_mask_o(mask1), .mem_data_i(mdin1)
    );

    mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid & cur), .req_ready_o(rdy3),
        .req_we_i(req_we), .req_funct3_i(req_f3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(rv3), .resp_rdata_o(rd3), .resp_misaligned_o(mis3),
        .mem_en_o(en3), .mem_address_o(maddr3), .mem_data_o(mdata3),
        .mem_wr_mask_o(mask3), .mem_data_i(mdin3)
    );

    // RAM models
    logic [31:0] ram1 [0:63];
    logic [31:0] ram3 [0:63];
    logic [31:0] pipe3 [0:2];

    always @(posedge clk) begin : ram1_model
        logic [31:0] w;
        if (en1) begin
            w = ram1[maddr1[7:2]];
            for (int b = 0; b < 4; b++)
                if (mask1[b]) w[8*b +: 8] = mdata1[8*b +: 8];
            ram1[maddr1[7:2]] <= w;
            mdin1 <= ram1[maddr1[7:2]];
        end
    end

    always @(posedge clk) begin : ram3_model
        logic [31:0] w;
        if (en3) begin
            w = ram3[maddr3[7:2]];
            for (int b = 0; b < 4; b++)
                if (mask3[b]) w[8*b +: 8] = mdata3[8*b +: 8];
            ram3[maddr3[7:2]] <= w;
            pipe3[0] <= ram3[maddr3[7:2]];
        end
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mdin3 = pipe3[2];

    // selected-instance view
    logic        w_rdy, w_rv, w_mis, w_en;
    logic [31:0] w_rd, w_maddr, w_mdata;
    logic [3:0]  w_mask;
    assign w_rdy   = cur ? rdy3   : rdy1;
    assign w_rv    = cur ? rv3    : rv1;
    assign w_mis   = cur ? mis3   : mis1;
    assign w_en    = cur ? en3    : en1;
    assign w_rd    = cur ? rd3    : rd1;
    assign w_maddr = cur ? maddr3 : maddr1;
    assign w_mdata = cur ? mdata3 : mdata1;
    assign w_mask  = cur ? mask3  : mask1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request and follow it until its response (bounded to 12 cycles).
    task automatic run_req(input logic inst, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rdata, output logic mis,
                           output int ens, output logic [3:0] mask, output logic [31:0] mdata,
                           output logic [31:0] maddr, output int busy_rdy, output int leak);
        @(negedge clk);
        cur       = inst;
        req_valid = 1'b1;
        req_we    = we;
        req_f3    = f3;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = 32'h0;
        lat = 0; rdata = 32'h0; mis = 1'b0; ens = 0; mask = 4'h0;
        mdata = 32'h0; maddr = 32'h0; busy_rdy = 0; leak = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            if (w_rdy) busy_rdy++;
            if (w_en) begin
                ens++;
                mask  = w_mask;
                mdata = w_mdata;
                maddr = w_maddr;
            end
            if (w_rv) begin
                lat   = k;
                rdata = w_rd;
                mis   = w_mis;
            end else if (w_rd != 32'h0 || w_mis) begin
                leak++;
            end
        end
    endtask

    typedef struct {
        logic        inst;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  mask;
        logic [31:0] mdata;
    } vec_t;

    vec_t vecs [0:20];

    initial begin
        int          lat, ens, busy, leak;
        logic [31:0] rdata, mdata, maddr;
        logic        mis;
        logic [3:0]  mask;

        for (int i = 0; i < 64; i++) begin
            ram1[i] = 32'h0;
            ram3[i] = 32'h0;
        end
        pipe3[0] = 32'h0; pipe3[1] = 32'h0; pipe3[2] = 32'h0;
        mdin1 = 32'h0;

        //          inst we  f3      addr       wdata         lat rdata          mis  mask     mdata
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 2, 32'h0,         1'b0, 4'b1111, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h23, 32'h000000A5, 2, 32'h0,         1'b0, 4'b1000, 32'hA5A5A5A5};
        vecs[2]  = '{1'b0, 1'b0, 3'b010, 32'h20, 32'h0,        3, 32'hA5ADBEEF,  1'b0, 4'b0000, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h20, 32'h80FF7F01, 2, 32'h0,         1'b0, 4'b1111, 32'h80FF7F01};
        vecs[4]  = '{1'b0, 1'b0, 3'b000, 32'h22, 32'h0,        3, 32'hFFFFFFFF,  1'b0, 4'b0000, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 3'b100, 32'h23, 32'h0,        3, 32'h00000080,  1'b0, 4'b0000, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 3'b001, 32'h22, 32'h0,        3, 32'hFFFF80FF,  1'b0, 4'b0000, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 3'b101, 32'h20, 32'h0,        3, 32'h00007F01,  1'b0, 4'b0000, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 3'b000, 32'h21, 32'h0,        3, 32'h0000007F,  1'b0, 4'b0000, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 3'b001, 32'h21, 32'h0,        1, 32'h0,         1'b1, 4'b0000, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 3'b010, 32'h22, 32'h0,        1, 32'h0,         1'b1, 4'b0000, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 3'b011, 32'h20, 32'h0,        1, 32'h0,         1'b1, 4'b0000, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 3'b001, 32'h26, 32'h00001234, 2, 32'h0,         1'b0, 4'b1100, 32'h12341234};
        vecs[13] = '{1'b0, 1'b0, 3'b010, 32'h24, 32'h0,        3, 32'h12340000,  1'b0, 4'b0000, 32'h0};
        vecs[14] = '{1'b0, 1'b1, 3'b100, 32'h24, 32'hFFFFFFFF, 1, 32'h0,         1'b1, 4'b0000, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 3'b010, 32'h21, 32'hFFFFFFFF, 1, 32'h0,         1'b1, 4'b0000, 32'h0};
        vecs[16] = '{1'b0, 1'b0, 3'b111, 32'h20, 32'h0,        1, 32'h0,         1'b1, 4'b0000, 32'h0};
        vecs[17] = '{1'b0, 1'b0, 3'b010, 32'h24, 32'h0,        3, 32'h12340000,  1'b0, 4'b0000, 32'h0};
        vecs[18] = '{1'b1, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 2, 32'h0,         1'b0, 4'b1111, 32'hCAFEF00D};
        vecs[19] = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        5, 32'hCAFEF00D,  1'b0, 4'b0000, 32'h0};
        vecs[20] = '{1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        5, 32'hFFFFCAFE,  1'b0, 4'b0000, 32'h0};

        // reset state
        cur = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst ready",    {31'h0, w_rdy},  32'h0);
        chk("rst rvalid",   {31'h0, w_rv},   32'h0);
        chk("rst rdata",    w_rd,            32'h0);
        chk("rst mis",      {31'h0, w_mis},  32'h0);
        chk("rst en",       {31'h0, w_en},   32'h0);
        chk("rst mask",     {28'h0, w_mask}, 32'h0);
        chk("rst maddr",    w_maddr,         32'h0);
        chk("rst mdata",    w_mdata,         32'h0);
        chk("rst ready3",   {31'h0, rdy3},   32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready after release",  {31'h0, rdy1}, 32'h1);
        chk("ready3 after release", {31'h0, rdy3}, 32'h1);

        // vector table
        for (int i = 0; i <= 20; i++) begin
            run_req(vecs[i].inst, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                    lat, rdata, mis, ens, mask, mdata, maddr, busy, leak);
            chk($sformatf("v%0d latency", i),   lat,             vecs[i].lat);
            chk($sformatf("v%0d rdata", i),     rdata,           vecs[i].rdata);
            chk($sformatf("v%0d misaligned", i), {31'h0, mis},   {31'h0, vecs[i].mis});
            chk($sformatf("v%0d en cycles", i), ens,             vecs[i].mis ? 0 : 1);
            chk($sformatf("v%0d ready busy", i), busy,           0);
            chk($sformatf("v%0d resp leak", i), leak,            0);
            if (!vecs[i].mis) begin
                chk($sformatf("v%0d wr mask", i), {28'h0, mask}, {28'h0, vecs[i].mask});
                chk($sformatf("v%0d address", i), maddr,         vecs[i].addr);
                if (vecs[i].we)
                    chk($sformatf("v%0d wr data", i), mdata,     vecs[i].mdata);
            end
        end

        // reset during the WAIT cycle of a load: dropped, no response
        @(negedge clk);
        cur = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("midrst issue en", {31'h0, w_en}, 32'h1);
        @(negedge clk);
        chk("midrst wait rvalid", {31'h0, w_rv}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst rvalid",   {31'h0, w_rv},   32'h0);
        chk("midrst rdata",    w_rd,            32'h0);
        chk("midrst mis",      {31'h0, w_mis},  32'h0);
        chk("midrst en",       {31'h0, w_en},   32'h0);
        chk("midrst mask",     {28'h0, w_mask}, 32'h0);
        chk("midrst maddr",    w_maddr,         32'h0);
        chk("midrst mdata",    w_mdata,         32'h0);
        chk("midrst ready",    {31'h0, w_rdy},  32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst rvalid",  {31'h0, w_rv},   32'h0);
        chk("postrst ready",   {31'h0, w_rdy},  32'h1);
        run_req(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, lat, rdata, mis, ens, mask, mdata, maddr, busy, leak);
        chk("postrst LW latency", lat,   3);
        chk("postrst LW rdata",   rdata, 32'h80FF7F01);
        chk("postrst LW mis",     {31'h0, mis}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
